// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and frame-length helper for the parametrised UART transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Frame length in bit-times; multiply by CLKS_PER_BIT for clock cycles.
   function automatic int frame_len(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side handshake of the UART transmitter: word, valid/ready and queue depth.
interface uart_tx_param_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4
);
   logic [DATA_BITS-1:0]        tx_data_in;
   logic                        tx_valid;
   logic                        tx_ready;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   modport master (output tx_data_in, tx_valid, input  tx_ready, fifo_count);
   modport slave  (input  tx_data_in, tx_valid, output tx_ready, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO, read-first: pop_data always shows the head entry combinationally.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered, LSB-first, optional parity, 1 or 2 stop bits.
//
//   state  | meaning
//   IDLE   | line high, waiting for a queued word
//   START  | start bit (low) for one bit-time
//   DATA   | shift register bit 0 on the line, DATA_BITS bit-times
//   PARITY | registered parity bit for one bit-time (skipped if none)
//   STOP   | line high for STOP_BITS bit-times, then next word or IDLE
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic            clock,
   input  logic            reset,
   uart_tx_param_if.slave  bus,
   output logic            tx_out,
   output logic            tx_busy
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(DATA_BITS);
   localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_ODD && PARITY_MODE != PAR_EVEN) ||
       (STOP_BITS != 1 && STOP_BITS != 2) ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $fatal(1, "uart_tx_param: illegal parameter combination");
   end

   uart_state_e          state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_q, par_d;
   logic                 tx_d;
   logic                 load_frame;

   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] fifo_data;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 baud_tick;

   assign bus.tx_ready = !fifo_full && !reset;
   assign push         = bus.tx_valid && bus.tx_ready;
   assign baud_tick    = (baud_q == '0);

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (bus.tx_data_in),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (bus.fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      idx_d      = idx_q;
      shreg_d    = shreg_q;
      par_d      = par_q;
      tx_d       = tx_out;
      load_frame = 1'b0;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) load_frame = 1'b1;
         end
         START: begin
            if (baud_tick) begin
               state_d = DATA;
               baud_d  = BAUD_LOAD;
               idx_d   = '0;
               tx_d    = shreg_q[0];
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         DATA: begin
            if (baud_tick) begin
               baud_d = BAUD_LOAD;
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  idx_d = '0;
                  if (PARITY_MODE != PAR_NONE) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         PARITY: begin
            if (baud_tick) begin
               state_d = STOP;
               baud_d  = BAUD_LOAD;
               idx_d   = '0;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         STOP: begin
            if (baud_tick) begin
               if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                  if (!fifo_empty) begin
                     load_frame = 1'b1;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                  end
               end else begin
                  idx_d  = idx_q + IDX_W'(1);
                  baud_d = BAUD_LOAD;
               end
            end else begin
               baud_d = baud_q - BAUD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      // Parity is latched with the word so the shifter can destroy its copy.
      if (load_frame) begin
         pop     = 1'b1;
         shreg_d = fifo_data;
         par_d   = (PARITY_MODE == PAR_ODD) ? ~(^fifo_data) : (^fifo_data);
         state_d = START;
         baud_d  = BAUD_LOAD;
         idx_d   = '0;
         tx_d    = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         tx_out  <= 1'b1;
         tx_busy <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
         tx_out  <= tx_d;
         tx_busy <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1, 8E1/8O1, 7N2 frames, FIFO back-to-back and reset abort.
module tb_uart_tx_param;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_e ();
   uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_o ();
   uart_tx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) bus_7 ();

   logic tx_a, busy_a, tx_e, busy_e, tx_o, busy_o, tx_7, busy_7;

   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_a (.clock(clock), .reset(reset), .bus(bus_a), .tx_out(tx_a), .tx_busy(busy_a));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_e (.clock(clock), .reset(reset), .bus(bus_e), .tx_out(tx_e), .tx_busy(busy_e));
   uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4))
      u_o (.clock(clock), .reset(reset), .bus(bus_o), .tx_out(tx_o), .tx_busy(busy_o));
   uart_tx_param #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4))
      u_7 (.clock(clock), .reset(reset), .bus(bus_7), .tx_out(tx_7), .tx_busy(busy_7));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_state tx=%b busy=%b count=%0d expected tx=1 busy=0 count=0",
                  tx_a, busy_a, bus_a.fifo_count);
      end
      n_checks++;
      if (bus_a.tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_low ready=%b expected 0", bus_a.tx_ready);
      end
      n_checks++;
      if (tx_e !== 1'b1 || tx_o !== 1'b1 || tx_7 !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_lines tx_e=%b tx_o=%b tx_7=%b expected all 1", tx_e, tx_o, tx_7);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (bus_a.tx_ready !== 1'b1 || tx_a !== 1'b1 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release ready=%b tx=%b busy=%b expected ready=1 tx=1 busy=0",
                  bus_a.tx_ready, tx_a, busy_a);
      end
   endtask

   task automatic test_8n1();
      logic [9:0] fr;
      fr = {1'b1, 8'hB3, 1'b0};
      bus_a.tx_data_in = 8'hB3;
      bus_a.tx_valid   = 1'b1;
      tick();
      bus_a.tx_valid = 1'b0;
      n_checks++;
      if (tx_a !== 1'b1 || bus_a.fifo_count !== 3'd1) begin
         n_fail++;
         $display("FAIL 8n1_accept tx=%b count=%0d expected tx=1 count=1", tx_a, bus_a.fifo_count);
      end
      for (int k = 1; k <= 40; k++) begin
         tick();
         n_checks++;
         if (tx_a !== fr[(k-1)/4] || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL 8n1_bit cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                     k, tx_a, busy_a, fr[(k-1)/4]);
         end
      end
      tick();
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL 8n1_end tx=%b busy=%b count=%0d expected tx=1 busy=0 count=0",
                  tx_a, busy_a, bus_a.fifo_count);
      end
   endtask

   task automatic test_parity();
      logic [10:0] fe;
      logic [10:0] fo;
      fe = {1'b1, 1'b1, 8'hB3, 1'b0};
      fo = {1'b1, 1'b0, 8'hB3, 1'b0};
      bus_e.tx_data_in = 8'hB3;
      bus_o.tx_data_in = 8'hB3;
      bus_e.tx_valid   = 1'b1;
      bus_o.tx_valid   = 1'b1;
      tick();
      bus_e.tx_valid = 1'b0;
      bus_o.tx_valid = 1'b0;
      for (int k = 1; k <= 44; k++) begin
         tick();
         n_checks++;
         if (tx_e !== fe[(k-1)/4] || busy_e !== 1'b1) begin
            n_fail++;
            $display("FAIL 8e1_bit cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                     k, tx_e, busy_e, fe[(k-1)/4]);
         end
         n_checks++;
         if (tx_o !== fo[(k-1)/4] || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL 8o1_bit cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                     k, tx_o, busy_o, fo[(k-1)/4]);
         end
      end
      tick();
      n_checks++;
      if (busy_e !== 1'b0 || busy_o !== 1'b0 || tx_e !== 1'b1 || tx_o !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_end busy_e=%b busy_o=%b tx_e=%b tx_o=%b expected 0 0 1 1",
                  busy_e, busy_o, tx_e, tx_o);
      end
   endtask

   task automatic test_7n2();
      logic [9:0] fr;
      fr = {2'b11, 7'h55, 1'b0};
      bus_7.tx_data_in = 7'h55;
      bus_7.tx_valid   = 1'b1;
      tick();
      bus_7.tx_valid = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         n_checks++;
         if (tx_7 !== fr[(k-1)/3] || busy_7 !== 1'b1) begin
            n_fail++;
            $display("FAIL 7n2_bit cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                     k, tx_7, busy_7, fr[(k-1)/3]);
         end
      end
      tick();
      n_checks++;
      if (tx_7 !== 1'b1 || busy_7 !== 1'b0) begin
         n_fail++;
         $display("FAIL 7n2_end tx=%b busy=%b expected tx=1 busy=0", tx_7, busy_7);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w [5];
      logic [9:0] fr [5];
      logic [9:0] cur;
      w = '{8'hA1, 8'h5C, 8'h0F, 8'hE7, 8'h3D};
      for (int i = 0; i < 5; i++) fr[i] = {1'b1, w[i], 1'b0};
      for (int i = 0; i < 5; i++) begin
         bus_a.tx_data_in = w[i];
         bus_a.tx_valid   = 1'b1;
         n_checks++;
         if (bus_a.tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready word=%0d ready=%b expected 1", i, bus_a.tx_ready);
         end
         tick();
         if (i >= 1) begin
            cur = fr[(i-1)/40];
            n_checks++;
            if (tx_a !== cur[((i-1)%40)/4]) begin
               n_fail++;
               $display("FAIL b2b_bit cycle=%0d tx=%b expected %b", i, tx_a, cur[((i-1)%40)/4]);
            end
         end
      end
      bus_a.tx_valid = 1'b0;
      n_checks++;
      if (bus_a.tx_ready !== 1'b0 || bus_a.fifo_count !== 3'd4) begin
         n_fail++;
         $display("FAIL b2b_full ready=%b count=%0d expected ready=0 count=4",
                  bus_a.tx_ready, bus_a.fifo_count);
      end
      for (int k = 5; k <= 200; k++) begin
         tick();
         cur = fr[(k-1)/40];
         n_checks++;
         if (tx_a !== cur[((k-1)%40)/4] || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_bit cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
                     k, tx_a, busy_a, cur[((k-1)%40)/4]);
         end
      end
      tick();
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL b2b_end tx=%b busy=%b count=%0d expected tx=1 busy=0 count=0",
                  tx_a, busy_a, bus_a.fifo_count);
      end
   endtask

   task automatic test_write_pop();
      logic [7:0] w [3];
      logic [9:0] fr1;
      int guard;
      w   = '{8'h11, 8'h22, 8'h33};
      fr1 = {1'b1, 8'h22, 1'b0};
      for (int i = 0; i < 3; i++) begin
         bus_a.tx_data_in = w[i];
         bus_a.tx_valid   = 1'b1;
         tick();
      end
      bus_a.tx_valid = 1'b0;
      for (int k = 3; k <= 40; k++) tick();
      n_checks++;
      if (tx_a !== 1'b1 || bus_a.fifo_count !== 3'd2) begin
         n_fail++;
         $display("FAIL wp_last_stop tx=%b count=%0d expected tx=1 count=2", tx_a, bus_a.fifo_count);
      end
      bus_a.tx_data_in = 8'h44;
      bus_a.tx_valid   = 1'b1;
      tick();
      bus_a.tx_valid = 1'b0;
      n_checks++;
      if (bus_a.fifo_count !== 3'd2 || tx_a !== 1'b0 || busy_a !== 1'b1) begin
         n_fail++;
         $display("FAIL wp_same_edge count=%0d tx=%b busy=%b expected count=2 tx=0 busy=1",
                  bus_a.fifo_count, tx_a, busy_a);
      end
      for (int k = 42; k <= 80; k++) begin
         tick();
         n_checks++;
         if (tx_a !== fr1[(k-41)/4]) begin
            n_fail++;
            $display("FAIL wp_frame2 cycle=%0d tx=%b expected %b", k, tx_a, fr1[(k-41)/4]);
         end
      end
      guard = 0;
      while (busy_a === 1'b1 && guard < 400) begin
         tick();
         guard++;
      end
      n_checks++;
      if (busy_a !== 1'b0 || bus_a.fifo_count !== 3'd0) begin
         n_fail++;
         $display("FAIL wp_drain busy=%b count=%0d expected busy=0 count=0 within 400 cycles",
                  busy_a, bus_a.fifo_count);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 3; i++) begin
         bus_a.tx_data_in = 8'h00;
         bus_a.tx_valid   = 1'b1;
         tick();
      end
      bus_a.tx_valid = 1'b0;
      for (int k = 3; k <= 17; k++) tick();
      n_checks++;
      if (tx_a !== 1'b0 || busy_a !== 1'b1 || bus_a.fifo_count !== 3'd2) begin
         n_fail++;
         $display("FAIL rst_pre tx=%b busy=%b count=%0d expected tx=0 busy=1 count=2",
                  tx_a, busy_a, bus_a.fifo_count);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus_a.tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready_comb ready=%b expected 0", bus_a.tx_ready);
      end
      tick();
      n_checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || bus_a.fifo_count !== 3'd0 || bus_a.tx_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_abort tx=%b busy=%b count=%0d ready=%b expected tx=1 busy=0 count=0 ready=0",
                  tx_a, busy_a, bus_a.fifo_count, bus_a.tx_ready);
      end
      reset = 1'b0;
      tick();
      n_checks++;
      if (bus_a.tx_ready !== 1'b1 || tx_a !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_after ready=%b tx=%b expected ready=1 tx=1", bus_a.tx_ready, tx_a);
      end
      for (int k = 0; k < 60; k++) begin
         tick();
         n_checks++;
         if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_quiet cycle=%0d tx=%b busy=%b expected tx=1 busy=0", k, tx_a, busy_a);
         end
      end
   endtask

   initial begin
      bus_a.tx_valid = 1'b0; bus_a.tx_data_in = '0;
      bus_e.tx_valid = 1'b0; bus_e.tx_data_in = '0;
      bus_o.tx_valid = 1'b0; bus_o.tx_data_in = '0;
      bus_7.tx_valid = 1'b0; bus_7.tx_data_in = '0;
      test_reset();
      test_8n1();
      repeat (3) tick();
      test_parity();
      repeat (3) tick();
      test_7n2();
      repeat (3) tick();
      test_back_to_back();
      repeat (3) tick();
      test_write_pop();
      repeat (3) tick();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the team's fixed-format UART transmitter. It takes bytes or words over a valid/ready handshake into an internal FIFO and serialises them LSB-first. The frame is start bit, DATA_BITS data bits, an optional parity bit, then 1 or 2 stop bits. It sits between on-chip producers (CPU bus bridge, debug logger) and the TX pad; back-to-back frames go out with no idle gap.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit (>=2)
DATA_BITS, 8, data bits per frame (5..9)
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits (1 or 2)
FIFO_DEPTH, 4, TX FIFO entries (power of 2, >=2)

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tx_data_in  input  DATA_BITS  word to transmit
tx_valid  input  1  producer offers tx_data_in
tx_ready  output  1  FIFO can accept a word
tx_out  output  1  serial line, idles high
tx_busy  output  1  a frame is on the line
fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently queued

Behaviour:
- Reset (sampled on clock edge while reset=1):
  - tx_out=1, tx_busy=0, fifo_count=0, FSM=IDLE, baud counter=0.
  - tx_ready is forced 0 while reset=1, and is 1 on the first cycle after.
  - Reset mid-frame aborts immediately: line returns high on that edge and queued data is discarded.
- Write:
  - Accepted on an edge where tx_valid && tx_ready.
  - tx_ready = !full, combinational from the count.
  - A write when full is impossible by construction; the producer must hold the word.
- Pop:
  - Occurs when FSM is IDLE and the FIFO is non-empty, or at the end of the last stop bit with the FIFO non-empty.
  - Pop and write on the same edge: fifo_count unchanged, data order preserved.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
  - IDLE: tx_out=1. Leaves on a non-empty FIFO by popping into the shift register and loading the baud counter.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: shift register bit 0 driven, shift right every CLKS_PER_BIT cycles. Bit index counts 0..DATA_BITS-1.
  - PARITY (skipped when PARITY_MODE=0):
    - even: tx_out = XOR of data bits.
    - odd: tx_out = inverted XOR of data bits.
    - Parity is computed at pop time and registered.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. Then pops the next word and goes to START if the FIFO is non-empty, otherwise goes to IDLE.
- Timing:
  - Latency: a write on edge N into an empty FIFO with the FSM IDLE gives tx_out=0 from edge N+1.
  - Every bit lasts exactly CLKS_PER_BIT cycles.
  - Frame length = (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_busy = (FSM != IDLE), registered with the state. It stays 1 continuously across back-to-back frames.
- tx_out is driven from a flop, so the pad output is glitch-free.
- Baud counter:
  - Counts down from CLKS_PER_BIT-1 to 0 and reloads on every bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
- Illegal parameter values are rejected by an elaboration-time check that stops elaboration.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - helper function frame_len(data_bits, parity, stop_bits)
- Sub-module uart_tx_fifo is a synchronous FIFO parametrised by WIDTH and DEPTH. It provides push, pop, data out, full, empty and count, with read-first on simultaneous push/pop.
- The FSM, baud counter and shifter stay in uart_tx_param.

Test Plan:
1. CLKS_PER_BIT=4, 8N1; after reset write 8'hB3 once.
   - Expected: tx_out low from the next edge.
   - Bits 1,1,0,0,1,1,0,1 each for 4 cycles, then high for 4 cycles.
   - tx_busy high for 40 cycles.
2. 8E1, write 8'hB3 (five ones).
   - Expected: parity bit = 1 and frame = 44 cycles.
   - With 8O1 instead: parity bit = 0.
3. FIFO_DEPTH=4: write 5 words back-to-back.
   - Expected: tx_ready drops after the 5th accept (1 in flight, 4 queued), fifo_count=4.
   - All 5 frames contiguous, no idle cycles between stop and start, order preserved.
4. Simultaneous write and pop at the end of a stop bit with fifo_count=2.
   - Expected: fifo_count stays 2 and the next start bit begins on the following edge.
5. Assert reset during DATA bit 3 of a frame with 2 words queued.
   - Expected: tx_out=1, tx_busy=0, fifo_count=0 on that edge.
   - tx_ready=0 during reset and 1 after.
   - No further transitions on tx_out.
6. DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=3, write 7'h55.
   - Expected: bits 1,0,1,0,1,0,1, then 6 high cycles.
   - Frame = 30 cycles.
